// File: rtl/rob_multi.sv
// Reorder buffer: one dispatch per cycle, NUM_CPL completion ports, in-order retire of up to
// COMMIT_W entries, and a single-cycle flush pulse when a mispredicted entry retires.
module rob_multi #(
    parameter int ROB_SIZE      = 16,
    parameter int ROB_IDX_BITS  = 4,
    parameter int PHYS_REG_BITS = 6,
    parameter int NUM_CPL       = 2,
    parameter int COMMIT_W      = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              alloc_en,
    input  logic [4:0]                        alloc_rd,
    input  logic [PHYS_REG_BITS-1:0]          alloc_phys_rd,
    input  logic [PHYS_REG_BITS-1:0]          alloc_old_phys,
    input  logic [31:0]                       alloc_pc,
    output logic                              alloc_ready,
    output logic [ROB_IDX_BITS-1:0]           alloc_idx,
    input  logic [NUM_CPL-1:0]                cpl_en,
    input  logic [NUM_CPL*ROB_IDX_BITS-1:0]   cpl_idx,
    input  logic [NUM_CPL*32-1:0]             cpl_result,
    input  logic [NUM_CPL-1:0]                cpl_mispredict,
    output logic [COMMIT_W-1:0]               commit_valid,
    output logic [COMMIT_W*5-1:0]             commit_rd,
    output logic [COMMIT_W*PHYS_REG_BITS-1:0] commit_phys_rd,
    output logic [COMMIT_W*PHYS_REG_BITS-1:0] commit_old_phys,
    output logic [COMMIT_W*32-1:0]            commit_result,
    output logic [COMMIT_W*32-1:0]            commit_pc,
    input  logic                              commit_ready,
    output logic                              flush,
    output logic [ROB_IDX_BITS:0]             count
);

    localparam int CNT_W = ROB_IDX_BITS + 1;

    logic [ROB_IDX_BITS-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     flush_q, flush_d;
    logic [ROB_SIZE-1:0]      valid_q, valid_d, done_q, done_d, misp_q, misp_d;
    logic [4:0]               rd_q     [ROB_SIZE];
    logic [4:0]               rd_d     [ROB_SIZE];
    logic [PHYS_REG_BITS-1:0] phys_q   [ROB_SIZE];
    logic [PHYS_REG_BITS-1:0] phys_d   [ROB_SIZE];
    logic [PHYS_REG_BITS-1:0] old_q    [ROB_SIZE];
    logic [PHYS_REG_BITS-1:0] old_d    [ROB_SIZE];
    logic [31:0]              pc_q     [ROB_SIZE];
    logic [31:0]              pc_d     [ROB_SIZE];
    logic [31:0]              result_q [ROB_SIZE];
    logic [31:0]              result_d [ROB_SIZE];

    logic [ROB_IDX_BITS-1:0]  slot_idx  [COMMIT_W];
    logic [ROB_IDX_BITS-1:0]  cpl_idx_w [NUM_CPL];
    logic [COMMIT_W-1:0]      slot_valid, slot_misp;
    logic [CNT_W-1:0]         slot_cnt, retire_cnt;
    logic                     chain, flush_pend, alloc_fire, retire, misp_retire;

    genvar gi;
    generate
        for (gi = 0; gi < COMMIT_W; gi++) begin : g_slot
            assign slot_idx[gi] = head_q + ROB_IDX_BITS'(gi);
            assign commit_rd[gi*5 +: 5] = slot_valid[gi] ? rd_q[slot_idx[gi]] : '0;
            assign commit_phys_rd[gi*PHYS_REG_BITS +: PHYS_REG_BITS] =
                slot_valid[gi] ? phys_q[slot_idx[gi]] : '0;
            assign commit_old_phys[gi*PHYS_REG_BITS +: PHYS_REG_BITS] =
                slot_valid[gi] ? old_q[slot_idx[gi]] : '0;
            assign commit_result[gi*32 +: 32] = slot_valid[gi] ? result_q[slot_idx[gi]] : '0;
            assign commit_pc[gi*32 +: 32]     = slot_valid[gi] ? pc_q[slot_idx[gi]] : '0;
        end
        for (gi = 0; gi < NUM_CPL; gi++) begin : g_cpl
            assign cpl_idx_w[gi] = cpl_idx[gi*ROB_IDX_BITS +: ROB_IDX_BITS];
        end
    endgenerate

    // Retire window is a thermometer: it stops at the first not-done entry and just after a mispredict.
    always_comb begin
        slot_valid = '0;
        slot_misp  = '0;
        slot_cnt   = '0;
        chain      = 1'b1;
        for (int i = 0; i < COMMIT_W; i++) begin
            if (chain && (count_q > CNT_W'(i)) && valid_q[slot_idx[i]] && done_q[slot_idx[i]]) begin
                slot_valid[i] = 1'b1;
                slot_misp[i]  = misp_q[slot_idx[i]];
                slot_cnt      = slot_cnt + CNT_W'(1);
                chain         = !misp_q[slot_idx[i]];
            end else begin
                chain = 1'b0;
            end
        end
    end

    assign flush_pend   = |slot_misp;
    assign alloc_ready  = (count_q < CNT_W'(ROB_SIZE)) && !flush_pend;
    assign alloc_fire   = alloc_en && alloc_ready;
    assign retire       = commit_ready && slot_valid[0];
    assign misp_retire  = retire && flush_pend;
    assign retire_cnt   = retire ? slot_cnt : '0;
    assign commit_valid = slot_valid;
    assign alloc_idx    = tail_q;
    assign count        = count_q;
    assign flush        = flush_q;

    always_comb begin
        valid_d  = valid_q;
        done_d   = done_q;
        misp_d   = misp_q;
        rd_d     = rd_q;
        phys_d   = phys_q;
        old_d    = old_q;
        pc_d     = pc_q;
        result_d = result_q;
        head_d   = head_q;
        tail_d   = tail_q;
        flush_d  = 1'b0;
        count_d  = count_q - retire_cnt + CNT_W'(alloc_fire);

        if (alloc_fire) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            misp_d[tail_q]  = 1'b0;
            rd_d[tail_q]    = alloc_rd;
            phys_d[tail_q]  = alloc_phys_rd;
            old_d[tail_q]   = alloc_old_phys;
            pc_d[tail_q]    = alloc_pc;
            tail_d          = tail_q + ROB_IDX_BITS'(1);
        end

        // Ascending port order lets the highest-numbered port win a same-index collision.
        for (int p = 0; p < NUM_CPL; p++) begin
            if (cpl_en[p] && valid_q[cpl_idx_w[p]]) begin
                done_d[cpl_idx_w[p]]   = 1'b1;
                misp_d[cpl_idx_w[p]]   = cpl_mispredict[p];
                result_d[cpl_idx_w[p]] = cpl_result[p*32 +: 32];
            end
        end

        if (retire) begin
            for (int i = 0; i < COMMIT_W; i++) begin
                if (slot_valid[i]) begin
                    valid_d[slot_idx[i]] = 1'b0;
                    done_d[slot_idx[i]]  = 1'b0;
                    misp_d[slot_idx[i]]  = 1'b0;
                end
            end
            head_d = head_q + retire_cnt[ROB_IDX_BITS-1:0];
        end

        if (misp_retire) begin
            valid_d = '0;
            done_d  = '0;
            misp_d  = '0;
            tail_d  = head_q + retire_cnt[ROB_IDX_BITS-1:0];
            count_d = '0;
            flush_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            flush_q <= 1'b0;
            valid_q <= '0;
            done_q  <= '0;
            misp_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            flush_q <= flush_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            misp_q  <= misp_d;
        end
    end

    // Payload is always qualified by valid/done, so it needs no reset.
    always_ff @(posedge clk) begin
        rd_q     <= rd_d;
        phys_q   <= phys_d;
        old_q    <= old_d;
        pc_q     <= pc_d;
        result_q <= result_d;
    end

endmodule
